// File: rtl/elastic_reg_pipe_if.sv
// Handshake bundle for elastic_reg_pipe: upstream/downstream valid-ready pairs,
// flush and the occupancy count. The DUT takes the slave side.
interface elastic_reg_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/elastic_reg_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with a combinational ready
// chain so empty stages keep accepting while the output side is stalled.
module elastic_reg_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_data,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q
);
  logic             vld_d;
  logic [WIDTH-1:0] data_d;

  // Data only moves with a valid item, so a bubble never overwrites a held value.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = up_vld;
      if (up_vld) data_d = up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end
endmodule

module elastic_reg_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst_n,
  elastic_reg_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            up_vld;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;
  logic [DEPTH:0]              rdy;
  logic [OCC_W-1:0]            occ;

  // A stage is ready if it is empty or everything below it can move.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !vld_q[i] || rdy[i+1];
    end
  end

  always_comb begin
    up_vld     = '0;
    up_data    = '0;
    up_vld[0]  = bus.in_valid;
    up_data[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_q[i-1];
      up_data[i] = data_q[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    elastic_reg_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (bus.flush),
      .load    (rdy[g]),
      .up_vld  (up_vld[g]),
      .up_data (up_data[g]),
      .vld_q   (vld_q[g]),
      .data_q  (data_q[g])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(vld_q[i]);
    end
  end

  assign bus.in_ready  = rdy[0] && !bus.flush;
  assign bus.out_valid = vld_q[DEPTH-1] && !bus.flush;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Bench for elastic_reg_pipe: directed scenarios plus random traffic, checked by
// a FIFO-of-items scoreboard with ready/latency rules derived from occupancy.
module tb_elastic_reg_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } item_t;

  logic clk;
  logic rst_n;
  int   cyc        = 0;
  int   checks     = 0;
  int   errors     = 0;
  int   last_stall = -1;
  item_t exp_q[$];

  elastic_reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  elastic_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Reference model: the pipe is a bounded FIFO of in-flight items. A stage is
  // empty somewhere iff fewer than DEPTH items are held, which decides in_ready;
  // with no stall since an item entered it must surface exactly DEPTH cycles later.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("occupancy", int'(bus.occupancy), exp_q.size());
      chk("in_ready", int'(bus.in_ready),
          int'(!bus.flush && (bus.out_ready || exp_q.size() < DEPTH)));
      if (bus.flush || exp_q.size() == 0)
        chk("out_valid_idle", int'(bus.out_valid), 0);
      else if (exp_q.size() == DEPTH)
        chk("out_valid_full", int'(bus.out_valid), 1);
      if (!bus.flush && exp_q.size() > 0 && last_stall < exp_q[0].acc)
        chk("latency", int'(bus.out_valid), int'((cyc - exp_q[0].acc) >= DEPTH));
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        chk("out_data", int'(bus.out_data), int'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{data: bus.in_data, acc: cyc});
      end
    end
    if (!bus.out_ready) last_stall = cyc;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    bus.out_ready = 1'b1;

    // Reset with traffic offered
    step();
    step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    at_neg();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_occupancy", int'(bus.occupancy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    step();

    // Streaming 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (DEPTH + 2) step();

    // Backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h21 + i);
      step();
    end
    bus.in_data = 8'h25;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_occupancy", int'(bus.occupancy), DEPTH);
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      if (k == 0) chk("bp_full_in_ready", int'(bus.in_ready), 1);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_data", int'(bus.out_data), 8'h21 + k);
      step();
      if (k == 0) bus.in_data = 8'h26;
      if (k == 1) bus.in_valid = 1'b0;
    end
    repeat (2) step();

    // Bubble collapse
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h31;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h32;
    at_neg();
    chk("bub_in_ready", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    repeat (DEPTH) step();
    at_neg();
    chk("bub_occupancy", int'(bus.occupancy), 2);
    step();
    bus.out_ready = 1'b1;
    at_neg();
    chk("bub_first_valid", int'(bus.out_valid), 1);
    chk("bub_first_data", int'(bus.out_data), 8'h31);
    step();
    at_neg();
    chk("bub_second_valid", int'(bus.out_valid), 1);
    chk("bub_second_data", int'(bus.out_data), 8'h32);
    step();
    repeat (2) step();

    // Flush with 3 stages filled
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h41 + i);
      step();
    end
    bus.flush   = 1'b1;
    bus.in_data = 8'h44;
    at_neg();
    chk("fl_in_ready", int'(bus.in_ready), 0);
    chk("fl_out_valid", int'(bus.out_valid), 0);
    step();
    bus.flush   = 1'b0;
    bus.in_data = 8'h45;
    at_neg();
    chk("fl_post_occ", int'(bus.occupancy), 0);
    chk("fl_post_out_valid", int'(bus.out_valid), 0);
    chk("fl_post_in_ready", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    repeat (DEPTH - 1) step();
    at_neg();
    chk("fl_lat_valid", int'(bus.out_valid), 1);
    chk("fl_lat_data", int'(bus.out_data), 8'h45);
    step();
    repeat (2) step();

    // Reset in the middle of a stream
    for (int i = 0; i < 16; i++) begin
      rst_n        = (i != 8);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h51 + i);
      if (i == 9) begin
        at_neg();
        chk("mrst_occupancy", int'(bus.occupancy), 0);
        chk("mrst_out_valid", int'(bus.out_valid), 0);
        chk("mrst_out_data", int'(bus.out_data), 0);
      end
      step();
    end
    bus.in_valid = 1'b0;
    repeat (DEPTH + 2) step();

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 49) == 0);
      rst_n         = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    at_neg();
    chk("drain_model_empty", exp_q.size(), 0);
    chk("drain_occupancy", int'(bus.occupancy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
